// File: rtl/lt24_pixel_bus_writer.sv
// Pixel-write responder that turns accepted pixels into LT24 (ILI9341)
// 8080-style bus writes. It skips the column/page window commands when a
// pixel continues the panel's auto-increment position.
module lt24_pixel_bus_writer #(
  parameter int WIDTH   = 240,
  parameter int HEIGHT  = 320,
  parameter int WR_LOW  = 2,
  parameter int WR_HIGH = 2
) (
  input  logic        clock,
  input  logic        globalRst_n,
  input  logic [7:0]  xAddr,
  input  logic [8:0]  yAddr,
  input  logic [15:0] pixelData,
  input  logic        pixelWrite,
  output logic        pixelReady,
  input  logic        resync,
  output logic        LT24Wr_n,
  output logic        LT24Rd_n,
  output logic        LT24CS_n,
  output logic        LT24RS,
  output logic [15:0] LT24Data
);

  typedef enum logic [2:0] {
    IDLE, CMD_COL, DAT_COL, CMD_PAGE, DAT_PAGE, CMD_MEM, PIX
  } state_t;

  localparam logic [7:0]  X_LAST      = 8'(WIDTH - 1);
  localparam logic [8:0]  Y_LAST      = 9'(HEIGHT - 1);
  localparam logic [15:0] COL_END_HI  = 16'(((WIDTH - 1) >> 8) & 255);
  localparam logic [15:0] COL_END_LO  = 16'((WIDTH - 1) & 255);
  localparam logic [15:0] PAGE_END_HI = 16'(((HEIGHT - 1) >> 8) & 255);
  localparam logic [15:0] PAGE_END_LO = 16'((HEIGHT - 1) & 255);
  localparam logic [7:0]  WORD_LAST   = 8'(WR_LOW + WR_HIGH - 1);
  localparam logic [7:0]  LOW_CNT     = 8'(WR_LOW);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, cnt_n;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  x_q, x_d, col_q, col_d, nx_q, nx_d;
  logic [8:0]  y_q, y_d, page_q, page_d, ny_q, ny_d;
  logic [15:0] pix_q, pix_d, data_q, data_d;
  logic        cvalid_q, cvalid_d, pend_q, pend_d, ready_q, ready_d;
  logic        wr_n_q, wr_n_d, cs_n_q, cs_n_d, rs_q, rs_d;
  logic        in_range, seq;

  function automatic logic [15:0] col_param(input logic [1:0] i, input logic [7:0] x);
    case (i)
      2'd0:    col_param = 16'h0000;
      2'd1:    col_param = {8'h00, x};
      2'd2:    col_param = COL_END_HI;
      default: col_param = COL_END_LO;
    endcase
  endfunction

  function automatic logic [15:0] page_param(input logic [1:0] i, input logic [8:0] y);
    case (i)
      2'd0:    page_param = {15'h0000, y[8]};
      2'd1:    page_param = {8'h00, y[7:0]};
      2'd2:    page_param = PAGE_END_HI;
      default: page_param = PAGE_END_LO;
    endcase
  endfunction

  assign in_range = ({24'd0, xAddr} < 32'(WIDTH)) && ({23'd0, yAddr} < 32'(HEIGHT));
  assign seq      = cvalid_q && (xAddr == nx_q) && (yAddr == ny_q) && !resync && !pend_q;
  assign cnt_n    = cnt_q + 8'd1;

  assign pixelReady = ready_q;
  assign LT24Wr_n   = wr_n_q;
  assign LT24Rd_n   = 1'b1;
  assign LT24CS_n   = cs_n_q;
  assign LT24RS     = rs_q;
  assign LT24Data   = data_q;

  // Next-state, bus word sequencing and cursor tracking.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    x_d      = x_q;
    y_d      = y_q;
    pix_d    = pix_q;
    col_d    = col_q;
    page_d   = page_q;
    nx_d     = nx_q;
    ny_d     = ny_q;
    cvalid_d = cvalid_q;
    pend_d   = pend_q | resync;
    ready_d  = ready_q;
    wr_n_d   = wr_n_q;
    cs_n_d   = cs_n_q;
    rs_d     = rs_q;
    data_d   = data_q;

    if (state_q == IDLE) begin
      ready_d = 1'b1;
      wr_n_d  = 1'b1;
      cs_n_d  = 1'b1;
      // Out-of-range pixels are consumed without touching bus, cursor or pending resync.
      if (pixelWrite && ready_q && in_range) begin
        x_d     = xAddr;
        y_d     = yAddr;
        pix_d   = pixelData;
        pend_d  = 1'b0;
        ready_d = 1'b0;
        cs_n_d  = 1'b0;
        wr_n_d  = 1'b0;
        cnt_d   = '0;
        idx_d   = '0;
        if (seq) begin
          state_d = PIX;
          rs_d    = 1'b1;
          data_d  = pixelData;
        end else begin
          state_d = CMD_COL;
          rs_d    = 1'b0;
          data_d  = 16'h002A;
          col_d   = xAddr;
          page_d  = yAddr;
        end
      end
    end else if (cnt_q != WORD_LAST) begin
      cnt_d  = cnt_n;
      wr_n_d = !(cnt_n < LOW_CNT);
    end else begin
      cnt_d  = '0;
      wr_n_d = 1'b0;
      case (state_q)
        CMD_COL: begin
          state_d = DAT_COL;
          idx_d   = '0;
          rs_d    = 1'b1;
          data_d  = col_param(2'd0, x_q);
        end
        DAT_COL: begin
          if (idx_q == 2'd3) begin
            state_d = CMD_PAGE;
            rs_d    = 1'b0;
            data_d  = 16'h002B;
          end else begin
            idx_d  = idx_q + 2'd1;
            data_d = col_param(idx_q + 2'd1, x_q);
          end
        end
        CMD_PAGE: begin
          state_d = DAT_PAGE;
          idx_d   = '0;
          rs_d    = 1'b1;
          data_d  = page_param(2'd0, y_q);
        end
        DAT_PAGE: begin
          if (idx_q == 2'd3) begin
            state_d = CMD_MEM;
            rs_d    = 1'b0;
            data_d  = 16'h002C;
          end else begin
            idx_d  = idx_q + 2'd1;
            data_d = page_param(idx_q + 2'd1, y_q);
          end
        end
        CMD_MEM: begin
          state_d = PIX;
          rs_d    = 1'b1;
          data_d  = pix_q;
        end
        PIX: begin
          state_d  = IDLE;
          ready_d  = 1'b1;
          cs_n_d   = 1'b1;
          wr_n_d   = 1'b1;
          cvalid_d = 1'b1;
          if (x_q == X_LAST) begin
            nx_d = col_q;
            ny_d = (y_q == Y_LAST) ? page_q : y_q + 9'd1;
          end else begin
            nx_d = x_q + 8'd1;
            ny_d = y_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and registered bus outputs; reset aborts any transfer in progress.
  always_ff @(posedge clock or negedge globalRst_n) begin
    if (!globalRst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      pix_q    <= '0;
      col_q    <= '0;
      page_q   <= '0;
      nx_q     <= '0;
      ny_q     <= '0;
      cvalid_q <= 1'b0;
      pend_q   <= 1'b0;
      ready_q  <= 1'b0;
      wr_n_q   <= 1'b1;
      cs_n_q   <= 1'b1;
      rs_q     <= 1'b1;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      x_q      <= x_d;
      y_q      <= y_d;
      pix_q    <= pix_d;
      col_q    <= col_d;
      page_q   <= page_d;
      nx_q     <= nx_d;
      ny_q     <= ny_d;
      cvalid_q <= cvalid_d;
      pend_q   <= pend_d;
      ready_q  <= ready_d;
      wr_n_q   <= wr_n_d;
      cs_n_q   <= cs_n_d;
      rs_q     <= rs_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: tb/tb_lt24_pixel_bus_writer.sv
// Directed bench for lt24_pixel_bus_writer: captures each bus word on the
// falling edge of LT24Wr_n and checks words, RS, CS_n span and turnaround.
module tb_lt24_pixel_bus_writer;

  logic        clock = 1'b0;
  logic        globalRst_n = 1'b0;
  logic [7:0]  xAddr = '0;
  logic [8:0]  yAddr = '0;
  logic [15:0] pixelData = '0;
  logic        pixelWrite = 1'b0;
  logic        pixelReady;
  logic        resync = 1'b0;
  logic        LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS;
  logic [15:0] LT24Data;

  int checks = 0;
  int errors = 0;

  logic [15:0] wd [16];
  logic        wrs [16];
  int          nw, cs_low, rdy_at, stab_err;

  lt24_pixel_bus_writer #(.WIDTH(240), .HEIGHT(320), .WR_LOW(2), .WR_HIGH(2)) dut (
    .clock(clock), .globalRst_n(globalRst_n), .xAddr(xAddr), .yAddr(yAddr),
    .pixelData(pixelData), .pixelWrite(pixelWrite), .pixelReady(pixelReady),
    .resync(resync), .LT24Wr_n(LT24Wr_n), .LT24Rd_n(LT24Rd_n),
    .LT24CS_n(LT24CS_n), .LT24RS(LT24RS), .LT24Data(LT24Data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Watch one transfer from the cycle after acceptance until pixelReady returns.
  task automatic collect(input int rs_at);
    logic prev_wr;
    nw = 0; cs_low = 0; rdy_at = 0; stab_err = 0; prev_wr = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clock);
      if (!LT24CS_n) cs_low++;
      if (prev_wr && !LT24Wr_n && nw < 16) begin
        wd[nw] = LT24Data; wrs[nw] = LT24RS; nw++;
      end else if (!LT24CS_n && nw > 0 && (LT24Data !== wd[nw-1] || LT24RS !== wrs[nw-1])) begin
        stab_err++;
      end
      prev_wr = LT24Wr_n;
      resync = (k == rs_at);
      if (pixelReady) begin rdy_at = k; break; end
    end
    resync = 1'b0;
  endtask

  task automatic send(input logic [7:0] x, input logic [8:0] y, input logic [15:0] d,
                      input bit coinc, input int rs_at, input bit do_collect);
    int w;
    w = 0;
    @(negedge clock);
    while (!pixelReady && w < 100) begin @(negedge clock); w++; end
    chk("ready_before_send", 32'(pixelReady), 32'd1);
    xAddr = x; yAddr = y; pixelData = d; pixelWrite = 1'b1; resync = coinc;
    @(posedge clock);
    #1;
    pixelWrite = 1'b0; resync = 1'b0;
    xAddr = 8'hA5; yAddr = 9'h15A; pixelData = 16'hDEAD;
    if (do_collect) collect(rs_at);
  endtask

  function automatic logic [15:0] exp_word(input int n, input logic [7:0] x,
                                           input logic [8:0] y, input logic [15:0] p);
    case (n)
      0:       exp_word = 16'h002A;
      1:       exp_word = 16'h0000;
      2:       exp_word = {8'h00, x};
      3:       exp_word = 16'h0000;
      4:       exp_word = 16'h00EF;
      5:       exp_word = 16'h002B;
      6:       exp_word = {15'h0000, y[8]};
      7:       exp_word = {8'h00, y[7:0]};
      8:       exp_word = 16'h0001;
      9:       exp_word = 16'h003F;
      10:      exp_word = 16'h002C;
      default: exp_word = p;
    endcase
  endfunction

  task automatic check_full(input string tag, input logic [7:0] x, input logic [8:0] y,
                            input logic [15:0] p);
    chk({tag, "_nwords"}, 32'(nw), 32'd12);
    for (int n = 0; n < 12 && n < nw; n++) begin
      chk($sformatf("%s_word%0d", tag, n), 32'(wd[n]), 32'(exp_word(n, x, y, p)));
      chk($sformatf("%s_rs%0d", tag, n), 32'(wrs[n]), 32'(!(n == 0 || n == 5 || n == 10)));
    end
    chk({tag, "_cs_low"}, 32'(cs_low), 32'd48);
    chk({tag, "_ready_at"}, 32'(rdy_at), 32'd49);
    chk({tag, "_stable"}, 32'(stab_err), 32'd0);
  endtask

  task automatic check_single(input string tag, input logic [15:0] p);
    chk({tag, "_nwords"}, 32'(nw), 32'd1);
    chk({tag, "_data"}, 32'(wd[0]), 32'(p));
    chk({tag, "_rs"}, 32'(wrs[0]), 32'd1);
    chk({tag, "_cs_low"}, 32'(cs_low), 32'd4);
    chk({tag, "_ready_at"}, 32'(rdy_at), 32'd5);
    chk({tag, "_stable"}, 32'(stab_err), 32'd0);
  endtask

  task automatic check_drop(input string tag);
    chk({tag, "_nwords"}, 32'(nw), 32'd0);
    chk({tag, "_cs_low"}, 32'(cs_low), 32'd0);
    chk({tag, "_ready_at"}, 32'(rdy_at), 32'd1);
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clock);
    chk("rst_ready", 32'(pixelReady), 32'd0);
    chk("rst_wr_n", 32'(LT24Wr_n), 32'd1);
    chk("rst_rd_n", 32'(LT24Rd_n), 32'd1);
    chk("rst_cs_n", 32'(LT24CS_n), 32'd1);
    chk("rst_rs", 32'(LT24RS), 32'd1);
    chk("rst_data", 32'(LT24Data), 32'd0);
    globalRst_n = 1'b1;
    @(negedge clock);
    chk("ready_after_release", 32'(pixelReady), 32'd1);

    // Test 1/2: first pixel full window, next pixel single word
    send(8'd0, 9'd0, 16'hF800, 1'b0, 0, 1'b1);
    check_full("t1", 8'd0, 9'd0, 16'hF800);
    send(8'd1, 9'd0, 16'h07E0, 1'b0, 0, 1'b1);
    check_single("t2", 16'h07E0);

    // Test 3: jump elsewhere
    send(8'd10, 9'd5, 16'h001F, 1'b0, 0, 1'b1);
    check_full("t3", 8'd10, 9'd5, 16'h001F);

    // Test 4: stream rest of row 5, wrap to colStart on row 6, then jump
    for (int unsigned i = 11; i < 240; i++) begin
      send(8'(i), 9'd5, {8'(i), 8'h5A}, 1'b0, 0, 1'b1);
      check_single("t4_stream", {8'(i), 8'h5A});
    end
    send(8'd10, 9'd6, 16'h1234, 1'b0, 0, 1'b1);
    check_single("t4_wrap", 16'h1234);
    send(8'd0, 9'd6, 16'h4321, 1'b0, 0, 1'b1);
    check_full("t4_jump", 8'd0, 9'd6, 16'h4321);

    // Test 5: out-of-range pixels are dropped and leave the cursor intact
    send(8'd240, 9'd0, 16'hAAAA, 1'b0, 0, 1'b1);
    check_drop("t5_x240");
    send(8'd0, 9'd320, 16'h5555, 1'b0, 0, 1'b1);
    check_drop("t5_y320");
    send(8'd1, 9'd6, 16'h0F0F, 1'b0, 0, 1'b1);
    check_single("t5_after", 16'h0F0F);

    // Test 6a: resync mid-transfer leaves it alone, forces next pixel full
    send(8'd2, 9'd6, 16'h2222, 1'b0, 2, 1'b1);
    check_single("t6_rs_mid", 16'h2222);
    send(8'd3, 9'd6, 16'h3333, 1'b0, 0, 1'b1);
    check_full("t6_rs_next", 8'd3, 9'd6, 16'h3333);
    // Test 6b: resync coincident with acceptance
    send(8'd4, 9'd6, 16'h4444, 1'b1, 0, 1'b1);
    check_full("t6_rs_coinc", 8'd4, 9'd6, 16'h4444);
    send(8'd5, 9'd6, 16'h5555, 1'b0, 0, 1'b1);
    check_single("t6_rs_clear", 16'h5555);

    // Bottom-right corner wraps the cursor back to the window origin
    send(8'd239, 9'd319, 16'h9999, 1'b0, 0, 1'b1);
    check_full("corner_full", 8'd239, 9'd319, 16'h9999);
    send(8'd239, 9'd319, 16'h8888, 1'b0, 0, 1'b1);
    check_single("corner_wrap", 16'h8888);

    // Test 6c: reset asserted during DAT_PAGE (cycle 30 is word 7, y low byte)
    send(8'd100, 9'd100, 16'h7777, 1'b0, 0, 1'b0);
    repeat (30) @(negedge clock);
    chk("t6_pre_data", 32'(LT24Data), 32'h64);
    chk("t6_pre_rs", 32'(LT24RS), 32'd1);
    chk("t6_pre_cs_n", 32'(LT24CS_n), 32'd0);
    chk("t6_pre_wr_n", 32'(LT24Wr_n), 32'd0);
    #2 globalRst_n = 1'b0;
    #1;
    chk("t6_rst_wr_n", 32'(LT24Wr_n), 32'd1);
    chk("t6_rst_cs_n", 32'(LT24CS_n), 32'd1);
    chk("t6_rst_ready", 32'(pixelReady), 32'd0);
    chk("t6_rst_data", 32'(LT24Data), 32'd0);
    repeat (2) @(negedge clock);
    globalRst_n = 1'b1;
    @(negedge clock);
    chk("t6_ready_release", 32'(pixelReady), 32'd1);
    send(8'd0, 9'd319, 16'h6666, 1'b0, 0, 1'b1);
    check_full("t6_after_reset", 8'd0, 9'd319, 16'h6666);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
